// File: rtl/aq_gemac_tx_mac.sv
// aq_gemac_tx_mac -- GMII transmit engine.
// Pulls frame bytes from the TX frame buffer, then drives preamble, SFD,
// data, zero pad up to MIN_FRAME, CRC-32 FCS and the inter-frame gap.
// Optional half-duplex collision handling (jam, retry, binary exponential
// backoff) is built only when AQ_GEMAC_TX_HALF_DUPLEX_EN is defined.
module aq_gemac_tx_mac #(
   parameter int MIN_FRAME  = 60,
   parameter int MAX_FRAME  = 1514,
   parameter int IFG_CYCLES = 12
) (
   input  logic        MAC_CLK,
   input  logic        RST_N,
   input  logic        MAC_REQ,
   output logic        MAC_RE,
   input  logic        MAC_EOP,
   input  logic [7:0]  MAC_DATA,
   output logic        MAC_FINISH,
   output logic        MAC_RETRY,
   input  logic        GMII_COL,
   output logic [7:0]  GMII_TXD,
   output logic        GMII_TX_EN,
   output logic        GMII_TX_ER,
   output logic [15:0] TX_FRAME_CNT
);

   localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
   localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME);
   localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);

`ifdef AQ_GEMAC_TX_HALF_DUPLEX_EN
   typedef enum logic [3:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG,
                             S_JAM, S_BACKOFF} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG} state_t;
`endif

   state_t      state, state_nx;
   logic [7:0]  cnt, cnt_nx;
   logic [10:0] byte_cnt, byte_nx, byte_inc;
   logic [31:0] crc, crc_nx, fcs;
   logic        err, err_nx;
   logic [7:0]  txd_nx;
   logic        en_nx, er_nx, finish_nx, good_nx;

`ifdef AQ_GEMAC_TX_HALF_DUPLEX_EN
   logic        retry, retry_nx;
   logic [4:0]  attempt, attempt_nx;
   logic [9:0]  lfsr, lfsr_nx, mask;
   logic [18:0] backoff, backoff_nx;
   logic        collide;

   // late collisions (64 or more data bytes out) are ignored
   assign collide = GMII_COL && (byte_cnt < 11'd64) &&
                    ((state == S_PRE) || (state == S_SFD) || (state == S_DATA) || (state == S_PAD));
   assign MAC_RETRY = retry;
`else
   logic unused_col;
   assign unused_col = GMII_COL;
   assign MAC_RETRY  = 1'b0;
`endif

   // byte-wide update of the reflected CRC-32 (poly 0xEDB88320)
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   assign byte_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
   assign fcs      = ~crc;

`ifdef AQ_GEMAC_TX_HALF_DUPLEX_EN
   // backoff slot mask: min(attempt, 10) low bits of the LFSR
   always_comb begin
      mask = '0;
      for (int i = 0; i < 10; i++) mask[i] = (5'(i) < attempt);
   end
`endif

   // next-state, next-output and byte-consume logic
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      byte_nx   = byte_cnt;
      crc_nx    = crc;
      err_nx    = err;
      txd_nx    = 8'h00;
      en_nx     = 1'b0;
      er_nx     = 1'b0;
      finish_nx = 1'b0;
      good_nx   = 1'b0;
      MAC_RE    = 1'b0;
`ifdef AQ_GEMAC_TX_HALF_DUPLEX_EN
      retry_nx   = 1'b0;
      attempt_nx = attempt;
      lfsr_nx    = lfsr;
      backoff_nx = backoff;
`endif
      case (state)
         S_IDLE: begin
            crc_nx  = '1;
            byte_nx = '0;
            err_nx  = 1'b0;
            cnt_nx  = '0;
            if (MAC_REQ) state_nx = S_PRE;
         end
         S_PRE: begin
            txd_nx = 8'h55;
            en_nx  = 1'b1;
            cnt_nx = cnt + 8'd1;
            if (cnt == 8'd6) begin
               cnt_nx   = '0;
               state_nx = S_SFD;
            end
         end
         S_SFD: begin
            txd_nx   = 8'hD5;
            en_nx    = 1'b1;
            state_nx = S_DATA;
         end
         S_DATA: begin
            en_nx = 1'b1;
            if (!MAC_REQ) begin
               // buffer underrun: poison the frame and give it up
               er_nx     = 1'b1;
               err_nx    = 1'b1;
               finish_nx = 1'b1;
               cnt_nx    = '0;
               state_nx  = S_IFG;
            end else begin
               MAC_RE  = 1'b1;
               txd_nx  = MAC_DATA;
               er_nx   = (byte_cnt >= MAX_LEN);
               if (byte_cnt >= MAX_LEN) err_nx = 1'b1;
               crc_nx  = crc_byte(crc, MAC_DATA);
               byte_nx = byte_inc;
               cnt_nx  = '0;
               if (MAC_EOP) state_nx = (byte_inc < MIN_LEN) ? S_PAD : S_FCS;
            end
         end
         S_PAD: begin
            en_nx   = 1'b1;
            crc_nx  = crc_byte(crc, 8'h00);
            byte_nx = byte_inc;
            if (byte_inc >= MIN_LEN) begin
               cnt_nx   = '0;
               state_nx = S_FCS;
            end
         end
         S_FCS: begin
            txd_nx = fcs[{cnt[1:0], 3'b000} +: 8];
            en_nx  = 1'b1;
            cnt_nx = cnt + 8'd1;
            if (cnt == 8'd3) begin
               finish_nx = 1'b1;
               good_nx   = !err;
               cnt_nx    = '0;
               state_nx  = S_IFG;
            end
         end
         S_IFG: begin
            cnt_nx = cnt + 8'd1;
            if (cnt == IFG_LAST) begin
               cnt_nx = '0;
               if (MAC_REQ) begin
                  // back-to-back frame: skip the idle cycle so the gap is exact
                  crc_nx   = '1;
                  byte_nx  = '0;
                  err_nx   = 1'b0;
                  state_nx = S_PRE;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
`ifdef AQ_GEMAC_TX_HALF_DUPLEX_EN
         S_JAM: begin
            txd_nx = 8'h55;
            en_nx  = 1'b1;
            cnt_nx = cnt + 8'd1;
            if (cnt == 8'd0) begin
               // err here means the attempt limit was hit: drop the frame
               finish_nx = err;
               retry_nx  = !err;
            end
            if (cnt == 8'd3) begin
               cnt_nx     = '0;
               backoff_nx = {lfsr & mask, 9'd0};
               state_nx   = err ? S_IFG : S_BACKOFF;
            end
         end
         S_BACKOFF: begin
            if (backoff == 19'd0) state_nx = S_IDLE;
            else backoff_nx = backoff - 19'd1;
         end
`endif
         default: state_nx = S_IDLE;
      endcase
`ifdef AQ_GEMAC_TX_HALF_DUPLEX_EN
      if (collide) begin
         state_nx   = S_JAM;
         cnt_nx     = '0;
         finish_nx  = 1'b0;
         good_nx    = 1'b0;
         err_nx     = (attempt == 5'd15);
         attempt_nx = attempt + 5'd1;
         lfsr_nx    = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      end
      if (finish_nx) attempt_nx = '0;
`endif
   end

   // FSM state, counters and running CRC
   always_ff @(posedge MAC_CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= S_IDLE;
         cnt      <= '0;
         byte_cnt <= '0;
         crc      <= '1;
         err      <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         byte_cnt <= byte_nx;
         crc      <= crc_nx;
         err      <= err_nx;
      end
   end

   // registered GMII, completion pulse and good-frame counter
   always_ff @(posedge MAC_CLK or negedge RST_N) begin
      if (!RST_N) begin
         GMII_TXD     <= 8'h00;
         GMII_TX_EN   <= 1'b0;
         GMII_TX_ER   <= 1'b0;
         MAC_FINISH   <= 1'b0;
         TX_FRAME_CNT <= 16'd0;
      end else begin
         GMII_TXD   <= txd_nx;
         GMII_TX_EN <= en_nx;
         GMII_TX_ER <= er_nx;
         MAC_FINISH <= finish_nx;
         if (good_nx) TX_FRAME_CNT <= TX_FRAME_CNT + 16'd1;
      end
   end

`ifdef AQ_GEMAC_TX_HALF_DUPLEX_EN
   // collision bookkeeping: retry pulse, attempts, LFSR, backoff timer
   always_ff @(posedge MAC_CLK or negedge RST_N) begin
      if (!RST_N) begin
         retry   <= 1'b0;
         attempt <= '0;
         lfsr    <= 10'h2A5;
         backoff <= '0;
      end else begin
         retry   <= retry_nx;
         attempt <= attempt_nx;
         lfsr    <= lfsr_nx;
         backoff <= backoff_nx;
      end
   end
`endif

endmodule
